// File: rtl/chamber_timer.sv
// Seconds timer answering fill/drain/wait requests from the interlock FSM.
// Optional TIMER_PAUSE_EN adds a pause input that freezes an active count.
module chamber_timer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int FILL_SECS  = 7,
    parameter int DRAIN_SECS = 8,
    parameter int WAIT_SECS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       filling,
    input  logic       draining,
    input  logic       waiting,
`ifdef TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       fillFinished,
    output logic       drainFinished,
    output logic       waitFinished,
    output logic       busy,
    output logic [7:0] secondsLeft
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

`ifndef SYNTHESIS
    if (TICK_DIV < 2 || FILL_SECS < 1 || DRAIN_SECS < 1 || WAIT_SECS < 1 ||
        FILL_SECS > 255 || DRAIN_SECS > 255 || WAIT_SECS > 255) begin : g_bad_cfg
        $error("chamber_timer: illegal TICK_DIV or duration parameter");
    end
`endif

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, WAIT, DONE} state_t;
    typedef enum logic [1:0] {K_FILL, K_DRAIN, K_WAIT} kind_t;

    state_t        state;
    kind_t         kind;
    logic [PW-1:0] prescaler;
    logic          active_req;
    logic          paused;

`ifdef TIMER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        active_req = 1'b0;
        unique case (kind)
            K_FILL:  active_req = filling;
            K_DRAIN: active_req = draining;
            K_WAIT:  active_req = waiting;
            default: active_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            kind          <= K_FILL;
            prescaler     <= '0;
            secondsLeft   <= '0;
            busy          <= 1'b0;
            fillFinished  <= 1'b0;
            drainFinished <= 1'b0;
            waitFinished  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (draining) begin
                        state       <= DRAIN;
                        kind        <= K_DRAIN;
                        secondsLeft <= 8'(DRAIN_SECS);
                        busy        <= 1'b1;
                    end else if (filling) begin
                        state       <= FILL;
                        kind        <= K_FILL;
                        secondsLeft <= 8'(FILL_SECS);
                        busy        <= 1'b1;
                    end else if (waiting) begin
                        state       <= WAIT;
                        kind        <= K_WAIT;
                        secondsLeft <= 8'(WAIT_SECS);
                        busy        <= 1'b1;
                    end
                end
                FILL, DRAIN, WAIT: begin
                    if (!active_req) begin
                        // Request withdrawn: abort without a finished pulse
                        state       <= IDLE;
                        prescaler   <= '0;
                        secondsLeft <= '0;
                        busy        <= 1'b0;
                    end else if (!paused) begin
                        if (prescaler == LAST) begin
                            prescaler <= '0;
                            if (secondsLeft == 8'd1) begin
                                state         <= DONE;
                                secondsLeft   <= '0;
                                busy          <= 1'b0;
                                fillFinished  <= (kind == K_FILL);
                                drainFinished <= (kind == K_DRAIN);
                                waitFinished  <= (kind == K_WAIT);
                            end else begin
                                secondsLeft <= secondsLeft - 8'd1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!active_req) begin
                        state         <= IDLE;
                        fillFinished  <= 1'b0;
                        drainFinished <= 1'b0;
                        waitFinished  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    prescaler   <= '0;
                    secondsLeft <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chamber_timer.sv
// Directed bench for chamber_timer with small timing parameters.
// Expected output words are queued with each stimulus step and popped at sample time.
module tb_chamber_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       filling;
    logic       draining;
    logic       waiting;
`ifdef TIMER_PAUSE_EN
    logic       pause;
`endif
    logic       fillFinished;
    logic       drainFinished;
    logic       waitFinished;
    logic       busy;
    logic [7:0] secondsLeft;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];

    chamber_timer #(
        .TICK_DIV  (4),
        .FILL_SECS (3),
        .DRAIN_SECS(2),
        .WAIT_SECS (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .filling      (filling),
        .draining     (draining),
        .waiting      (waiting),
`ifdef TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .fillFinished (fillFinished),
        .drainFinished(drainFinished),
        .waitFinished (waitFinished),
        .busy         (busy),
        .secondsLeft  (secondsLeft)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {fillFinished, drainFinished, waitFinished, busy, secondsLeft};
    endfunction

    task automatic push(input string tag, input logic [2:0] fin,
                        input logic bsy, input logic [7:0] secs);
        exp_t e;
        e.tag = tag;
        e.val = {fin, bsy, secs};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [11:0] obs;
        e = sb.pop_front();
        obs = observed();
        checks++;
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed fin/busy/secs=%03b/%b/%0d expected=%03b/%b/%0d",
                   e.tag, obs[11:9], obs[8], obs[7:0],
                   e.val[11:9], e.val[8], e.val[7:0]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expectation, advance n edges, then compare
    task automatic expect_after(input int n, input string tag, input logic [2:0] fin,
                                input logic bsy, input logic [7:0] secs);
        push(tag, fin, bsy, secs);
        step(n);
        check();
    endtask

    initial begin
        reset    = 1'b1;
        filling  = 1'b0;
        draining = 1'b0;
        waiting  = 1'b0;
`ifdef TIMER_PAUSE_EN
        pause    = 1'b0;
`endif
        expect_after(2, "reset_state", 3'b000, 1'b0, 8'd0);
        reset = 1'b0;
        expect_after(2, "idle_after_reset", 3'b000, 1'b0, 8'd0);

        // 1: fill count and handshake
        filling = 1'b1;
        expect_after(1,  "fill_e0",  3'b000, 1'b1, 8'd3);
        expect_after(3,  "fill_e3",  3'b000, 1'b1, 8'd3);
        expect_after(1,  "fill_e4",  3'b000, 1'b1, 8'd2);
        expect_after(4,  "fill_e8",  3'b000, 1'b1, 8'd1);
        expect_after(3,  "fill_e11", 3'b000, 1'b1, 8'd1);
        expect_after(1,  "fill_e12", 3'b100, 1'b0, 8'd0);
        expect_after(2,  "fill_hold", 3'b100, 1'b0, 8'd0);
        filling = 1'b0;
        expect_after(1,  "fill_release", 3'b000, 1'b0, 8'd0);
        expect_after(2,  "fill_idle", 3'b000, 1'b0, 8'd0);

        // 2: drain beats wait
        draining = 1'b1;
        waiting  = 1'b1;
        expect_after(1,  "prio_e0", 3'b000, 1'b1, 8'd2);
        expect_after(7,  "prio_e7", 3'b000, 1'b1, 8'd1);
        expect_after(1,  "prio_e8", 3'b010, 1'b0, 8'd0);
        expect_after(3,  "prio_hold", 3'b010, 1'b0, 8'd0);
        draining = 1'b0;
        waiting  = 1'b0;
        expect_after(1,  "prio_release", 3'b000, 1'b0, 8'd0);
        expect_after(3,  "prio_idle", 3'b000, 1'b0, 8'd0);

        // 3: wait aborted mid-count
        waiting = 1'b1;
        expect_after(1,  "abort_e0",  3'b000, 1'b1, 8'd5);
        expect_after(10, "abort_e10", 3'b000, 1'b1, 8'd3);
        waiting = 1'b0;
        expect_after(1,  "abort_e11", 3'b000, 1'b0, 8'd0);
        expect_after(20, "abort_quiet", 3'b000, 1'b0, 8'd0);

        // 4: async reset mid-fill
        filling = 1'b1;
        expect_after(1,  "rst_e0", 3'b000, 1'b1, 8'd3);
        expect_after(4,  "rst_e4", 3'b000, 1'b1, 8'd2);
        #2;
        reset = 1'b1;
        push("rst_async", 3'b000, 1'b0, 8'd0);
        #1;
        check();
        filling = 1'b0;
        #1;
        reset = 1'b0;
        expect_after(15, "rst_quiet", 3'b000, 1'b0, 8'd0);

        // 5: held request not re-armed, then re-armed after a low cycle
        filling = 1'b1;
        expect_after(1,  "rearm_e0",  3'b000, 1'b1, 8'd3);
        expect_after(12, "rearm_e12", 3'b100, 1'b0, 8'd0);
        expect_after(5,  "rearm_held", 3'b100, 1'b0, 8'd0);
        filling = 1'b0;
        expect_after(1,  "rearm_low", 3'b000, 1'b0, 8'd0);
        filling = 1'b1;
        expect_after(1,  "rearm_new_e0",  3'b000, 1'b1, 8'd3);
        expect_after(11, "rearm_new_e11", 3'b000, 1'b1, 8'd1);
        expect_after(1,  "rearm_new_e12", 3'b100, 1'b0, 8'd0);
        filling = 1'b0;
        expect_after(1,  "rearm_release", 3'b000, 1'b0, 8'd0);

`ifdef TIMER_PAUSE_EN
        // 6: pause freezes a wait count for six cycles
        waiting = 1'b1;
        expect_after(1,  "pause_e0",  3'b000, 1'b1, 8'd5);
        expect_after(4,  "pause_e4",  3'b000, 1'b1, 8'd4);
        pause = 1'b1;
        expect_after(6,  "pause_e10", 3'b000, 1'b1, 8'd4);
        pause = 1'b0;
        expect_after(4,  "pause_e14", 3'b000, 1'b1, 8'd3);
        expect_after(11, "pause_e25", 3'b000, 1'b1, 8'd1);
        expect_after(1,  "pause_e26", 3'b001, 1'b0, 8'd0);
        pause = 1'b1;
        expect_after(2,  "pause_done", 3'b001, 1'b0, 8'd0);
        pause   = 1'b0;
        waiting = 1'b0;
        expect_after(1,  "pause_release", 3'b000, 1'b0, 8'd0);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
